// File: rtl/accelbrot_com_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the com TX FIFO write port from NUM_REQ producers.
// Optional per-packet header word is enabled by defining ACCELBROT_COM_ARB_HDR_EN.
module accelbrot_com_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            out_valid,
   output logic                            out_last,
   output logic [DATA_WIDTH-1:0]           out_data,
   input  logic                            out_ready,
   output logic                            busy,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic [CNT_WIDTH-1:0]            pkt_words
);

   localparam int ID_W = $clog2(NUM_REQ);
   // One extra bit so rr_ptr + offset can exceed NUM_REQ before wrapping.
   localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

`ifdef ACCELBROT_COM_ARB_HDR_EN
   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_XFER} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_XFER} state_t;
`endif

   state_t                 state_q, state_d;
   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]        grant_q, grant_d;
   logic [CNT_WIDTH-1:0]   pkt_words_q, pkt_words_d;

   logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];
   logic                   sel_found;
   logic [ID_W-1:0]        sel_id;
   logic [ID_W:0]          scan_sum;
   logic [ID_W-1:0]        scan_idx;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin scan starting just after the last packet's owner.
   always_comb begin
      // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
      sel_found = 1'b0;
      sel_id    = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (scan_sum >= NUM_REQ_W) begin
            scan_sum = scan_sum - NUM_REQ_W;
         end
         scan_idx = scan_sum[ID_W-1:0];
         if (!sel_found && req_valid[scan_idx]) begin
            sel_found = 1'b1;
            sel_id    = scan_idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      pkt_words_d = pkt_words_q;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      out_data    = '0;
      req_ready   = '0;

      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               grant_d     = sel_id;
               pkt_words_d = '0;
`ifdef ACCELBROT_COM_ARB_HDR_EN
               state_d     = ST_HDR;
`else
               state_d     = ST_XFER;
`endif
            end
         end

`ifdef ACCELBROT_COM_ARB_HDR_EN
         ST_HDR: begin
            out_valid = 1'b1;
            out_data  = DATA_WIDTH'({4'hA, 4'(grant_q)});
            if (out_ready) begin
               state_d = ST_XFER;
            end
         end
`endif

         ST_XFER: begin
            out_valid          = req_valid[grant_q];
            out_last           = req_last[grant_q];
            out_data           = req_word[grant_q];
            req_ready[grant_q] = out_ready;
            if (out_valid && out_ready) begin
               if (pkt_words_q != '1) begin
                  pkt_words_d = pkt_words_q + 1'b1;
               end
               if (out_last) begin
                  rr_ptr_d = grant_q;
                  state_d  = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments; reset here is synchronous to clk.
      if (!rstn) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= ID_W'(NUM_REQ-1);
         grant_q     <= '0;
         pkt_words_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         pkt_words_q <= pkt_words_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign grant_id  = grant_q;
   assign pkt_words = pkt_words_q;

endmodule

// File: tb/tb_accelbrot_com_tx_arbiter.sv
// Directed bench for accelbrot_com_tx_arbiter: per-requester word queues drive the inputs,
// a log captures every accepted output word, and expectations are hand-computed.
module tb_accelbrot_com_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int CW = 16;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NR-1:0]     req_valid, req_last, req_ready;
   logic [NR*DW-1:0]  req_data;
   logic              out_valid, out_last, out_ready, busy;
   logic [DW-1:0]     out_data;
   logic [1:0]        grant_id;
   logic [CW-1:0]     pkt_words;

   always #5 clk = ~clk;

   accelbrot_com_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
      .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .grant_id(grant_id), .pkt_words(pkt_words)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Requester word queues
   logic [DW-1:0] wd [NR][16];
   logic          wl [NR][16];
   int            wn [NR];
   int            wp [NR];

   // Output log
   logic [DW-1:0] lg_d [32];
   logic          lg_l [32];
   int            lg_t [32];
   int            nlog = 0;
   int            cyc = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int r, input logic [DW-1:0] d, input logic l);
      wd[r][wn[r]] = d;
      wl[r][wn[r]] = l;
      wn[r]++;
   endtask

   task automatic clear_q();
      for (int r = 0; r < NR; r++) begin
         wn[r] = 0;
         wp[r] = 0;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (wp[i] < wn[i]) begin
            req_valid[i]         = 1'b1;
            req_last[i]          = wl[i][wp[i]];
            req_data[i*DW +: DW] = wd[i][wp[i]];
         end else begin
            req_valid[i]         = 1'b0;
            req_last[i]          = 1'b0;
            req_data[i*DW +: DW] = '0;
         end
      end
   endtask

   // Record handshakes seen before the edge, advance one clock, re-drive inputs.
   task automatic cycle();
      if (out_valid === 1'b1 && out_ready === 1'b1 && nlog < 32) begin
         lg_d[nlog] = out_data;
         lg_l[nlog] = out_last;
         lg_t[nlog] = cyc;
         nlog++;
      end
      for (int i = 0; i < NR; i++) begin
         if (req_valid[i] && req_ready[i] === 1'b1) wp[i]++;
      end
      @(posedge clk);
      #1;
      cyc++;
      drive();
      #1;
   endtask

   task automatic run_until(input int n, input int budget);
      int b;
      b = 0;
      while (nlog < n && b < budget) begin
         cycle();
         b++;
      end
      check("log_count", 64'(nlog), 64'(n));
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      clear_q();
      drive();
      cycle();
      cycle();
      rstn = 1'b1;
      nlog = 0;
   endtask

   logic [DW-1:0] exp2 [10];

   initial begin
      out_ready = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      do_reset();

      check("rst_busy",      64'(busy),      64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last",  64'(out_last),  64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_grant",     64'(grant_id),  64'd0);
      check("rst_pkt_words", 64'(pkt_words), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);

`ifdef ACCELBROT_COM_ARB_HDR_EN
      // Header precedes a single-word packet from req2
      push(2, 32'h55, 1'b1);
      drive();
      #1;
      cycle();
      check("hdr_valid",     64'(out_valid), 64'd1);
      check("hdr_data",      64'(out_data),  64'h0000_00A2);
      check("hdr_last",      64'(out_last),  64'd0);
      check("hdr_req_ready", 64'(req_ready), 64'd0);
      check("hdr_busy",      64'(busy),      64'd1);
      run_until(2, 10);
      check("hdr_log0",  64'(lg_d[0]), 64'h0000_00A2);
      check("hdr_last0", 64'(lg_l[0]), 64'd0);
      check("hdr_log1",  64'(lg_d[1]), 64'h55);
      check("hdr_last1", 64'(lg_l[1]), 64'd1);
      check("hdr_words", 64'(pkt_words), 64'd1);
`else
      // 1: three-word packet from req0 after one bubble cycle
      push(0, 32'h11, 1'b0);
      push(0, 32'h12, 1'b0);
      push(0, 32'h13, 1'b1);
      drive();
      #1;
      check("t1_bubble_valid", 64'(out_valid), 64'd0);
      cycle();
      check("t1_w0_data",  64'(out_data),  64'h11);
      check("t1_w0_ready", 64'(req_ready), 64'b0001);
      check("t1_busy",     64'(busy),      64'd1);
      cycle();
      check("t1_w1_data",  64'(out_data),  64'h12);
      check("t1_w1_last",  64'(out_last),  64'd0);
      cycle();
      check("t1_w2_data",  64'(out_data),  64'h13);
      check("t1_w2_last",  64'(out_last),  64'd1);
      cycle();
      check("t1_busy_after", 64'(busy),      64'd0);
      check("t1_pkt_words",  64'(pkt_words), 64'd3);
      check("t1_consec",     64'(lg_t[2] - lg_t[0]), 64'd2);

      // 2: all four requesters with 2-word packets, req0 has a second packet
      do_reset();
      push(0, 32'h101, 1'b0); push(0, 32'h102, 1'b1);
      push(0, 32'h105, 1'b0); push(0, 32'h106, 1'b1);
      push(1, 32'h201, 1'b0); push(1, 32'h202, 1'b1);
      push(2, 32'h301, 1'b0); push(2, 32'h302, 1'b1);
      push(3, 32'h401, 1'b0); push(3, 32'h402, 1'b1);
      exp2 = '{32'h101, 32'h102, 32'h201, 32'h202, 32'h301,
               32'h302, 32'h401, 32'h402, 32'h105, 32'h106};
      drive();
      #1;
      run_until(10, 60);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t2_data%0d", i), 64'(lg_d[i]), 64'(exp2[i]));
         check($sformatf("t2_last%0d", i), 64'(lg_l[i]), 64'(i % 2));
      end
      check("t2_span", 64'(lg_t[9] - lg_t[0]), 64'd13);

      // 3: backpressure mid-packet on req1
      nlog = 0;
      push(1, 32'h51, 1'b0); push(1, 32'h52, 1'b0);
      push(1, 32'h53, 1'b0); push(1, 32'h54, 1'b1);
      drive();
      #1;
      cycle();
      check("t3_grant", 64'(grant_id), 64'd1);
      check("t3_w0",    64'(out_data), 64'h51);
      cycle();
      out_ready = 1'b0;
      #1;
      for (int s = 0; s < 5; s++) begin
         check("t3_stall_valid", 64'(out_valid), 64'd1);
         check("t3_stall_data",  64'(out_data),  64'h52);
         check("t3_stall_ready", 64'(req_ready), 64'd0);
         check("t3_stall_words", 64'(pkt_words), 64'd1);
         cycle();
      end
      out_ready = 1'b1;
      #1;
      run_until(4, 20);
      check("t3_d0", 64'(lg_d[0]), 64'h51);
      check("t3_d1", 64'(lg_d[1]), 64'h52);
      check("t3_d2", 64'(lg_d[2]), 64'h53);
      check("t3_d3", 64'(lg_d[3]), 64'h54);
      check("t3_l2", 64'(lg_l[2]), 64'd0);
      check("t3_l3", 64'(lg_l[3]), 64'd1);
      check("t3_words", 64'(pkt_words), 64'd4);

      // 4: req2 moves rr_ptr to 2, then req3 must beat req1
      nlog = 0;
      push(2, 32'h62, 1'b1);
      push(1, 32'h61, 1'b1);
      push(3, 32'h63, 1'b1);
      drive();
      #1;
      run_until(3, 20);
      check("t4_first",  64'(lg_d[0]), 64'h62);
      check("t4_second", 64'(lg_d[1]), 64'h63);
      check("t4_third",  64'(lg_d[2]), 64'h61);
      check("t4_rate",   64'(lg_t[2] - lg_t[1]), 64'd2);
      check("t4_grant",  64'(grant_id), 64'd1);

      // 5: reset on the 2nd word of a 4-word packet, then a clean req2 packet
      nlog = 0;
      push(0, 32'h71, 1'b0); push(0, 32'h72, 1'b0);
      push(0, 32'h73, 1'b0); push(0, 32'h74, 1'b1);
      drive();
      #1;
      cycle();
      cycle();
      check("t5_w1", 64'(out_data), 64'h72);
      rstn = 1'b0;
      cycle();
      check("t5_busy",      64'(busy),      64'd0);
      check("t5_out_valid", 64'(out_valid), 64'd0);
      check("t5_grant",     64'(grant_id),  64'd0);
      check("t5_words",     64'(pkt_words), 64'd0);
      check("t5_req_ready", 64'(req_ready), 64'd0);
      check("t5_out_data",  64'(out_data),  64'd0);
      clear_q();
      rstn = 1'b1;
      nlog = 0;
      push(2, 32'h81, 1'b0);
      push(2, 32'h82, 1'b1);
      drive();
      #1;
      run_until(2, 20);
      check("t5_d0",    64'(lg_d[0]), 64'h81);
      check("t5_d1",    64'(lg_d[1]), 64'h82);
      check("t5_l1",    64'(lg_l[1]), 64'd1);
      check("t5_g2",    64'(grant_id), 64'd2);
      check("t5_words2", 64'(pkt_words), 64'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
